// File: rtl/trax_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trax_pkg
//  Description : Shared Trax definitions: tile codes, move word layout,
//                board limits, ASCII constants and the line formatter.
//  Revision    : 1.0 - initial release
// ============================================================================
package trax_pkg;

    // Tile codes as carried in the move word
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        PLUS   = 2'b01,
        SLASH  = 2'b10,
        BSLASH = 2'b11
    } tile_e;

    // Move word layout: [21:20] tile, [19:10] column, [9:0] row
    localparam int c_move_w   = 22;
    localparam int c_col_w    = 10;
    localparam int c_row_w    = 10;
    localparam int c_tile_msb = 21;
    localparam int c_tile_lsb = 20;
    localparam int c_col_msb  = 19;
    localparam int c_col_lsb  = 10;
    localparam int c_row_msb  = 9;
    localparam int c_row_lsb  = 0;

    // Board defaults
    localparam int MAX_COL = 26;
    localparam int MAX_ROW = 999;

    // ASCII constants
    localparam logic [7:0] c_ascii_at     = 8'h40;
    localparam logic [7:0] c_ascii_0      = 8'h30;
    localparam logic [7:0] c_ascii_plus   = 8'h2B;
    localparam logic [7:0] c_ascii_slash  = 8'h2F;
    localparam logic [7:0] c_ascii_bslash = 8'h5C;
    localparam logic [7:0] c_ascii_lf     = 8'h0A;

    // Longest line: letter, three digits, tile, LF
    localparam int c_line_max = 6;

    typedef struct packed {
        tile_e              tile;
        logic [c_col_w-1:0] col;
        logic [c_row_w-1:0] row;
    } move_t;

    typedef struct packed {
        logic [c_line_max-1:0][7:0] bytes;
        logic [2:0]                 count;
    } line_t;

    // Tile code to notation character; EMPTY never reaches the formatter
    function automatic logic [7:0] tile_char(input tile_e tile);
        logic [7:0] ch;
        case (tile)
            PLUS:    ch = c_ascii_plus;
            SLASH:   ch = c_ascii_slash;
            default: ch = c_ascii_bslash;
        endcase
        return ch;
    endfunction

    // Pack letter, row digits without leading zeros, tile and LF
    function automatic line_t build_line(
        input tile_e      tile,
        input logic [4:0] col,
        input logic [3:0] hund,
        input logic [3:0] tens,
        input logic [3:0] units
    );
        line_t      l;
        logic [2:0] n;
        l          = '0;
        l.bytes[0] = c_ascii_at + {3'b000, col};
        n          = 3'd1;
        if (hund != 4'd0) begin
            l.bytes[n] = c_ascii_0 + {4'b0000, hund};
            n          = n + 3'd1;
        end
        // A tens digit is kept whenever a hundreds digit precedes it
        if ((hund != 4'd0) || (tens != 4'd0)) begin
            l.bytes[n] = c_ascii_0 + {4'b0000, tens};
            n          = n + 3'd1;
        end
        l.bytes[n] = c_ascii_0 + {4'b0000, units};
        n          = n + 3'd1;
        l.bytes[n] = tile_char(tile);
        n          = n + 3'd1;
        l.bytes[n] = c_ascii_lf;
        n          = n + 3'd1;
        l.count    = n;
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 byte serialiser with valid/ready handshake. Ready is
//                also raised in the final cycle of a stop bit so that
//                back-to-back bytes leave no idle gap on the line.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int                 c_cnt_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    // Bit slots: 0 start, 1..8 data, 9 stop
    localparam logic [3:0]         c_bit_stop = 4'd9;
    localparam logic [3:0]         c_bit_last_data = 4'd8;

    logic               active_q, active_d;
    logic [3:0]         bit_q, bit_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               w_bit_end;

    assign w_bit_end = active_q && (cnt_q == c_cnt_last);
    assign o_ready   = !active_q || (w_bit_end && (bit_q == c_bit_stop));
    assign o_tx      = tx_q;

    // Bit timing, shifting and next line level
    always_comb begin
        active_d = active_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (i_valid && o_ready) begin
            active_d = 1'b1;
            bit_d    = 4'd0;
            cnt_d    = '0;
            shift_d  = i_data;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (w_bit_end) begin
                cnt_d = '0;
                if (bit_q == c_bit_stop) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q < c_bit_last_data) begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end else begin
                        tx_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + c_cnt_w'(1);
            end
        end
    end

    // Serialiser state registers; line idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            bit_q    <= 4'd0;
            cnt_q    <= '0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trax_move_tx.sv
`default_nettype none
// ============================================================================
//  Module      : trax_move_tx
//  Description : Formats a 22-bit Trax move as an ASCII notation line
//                (column letter, decimal row, tile char, LF) and sends it
//                on an 8N1 UART line.
//  Revision    : 1.0 - initial release
// ============================================================================
module trax_move_tx
    import trax_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_COL      = trax_pkg::MAX_COL,
    parameter int MAX_ROW      = trax_pkg::MAX_ROW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [c_move_w-1:0] move_in,
    input  logic                start_transmit,
    output logic                tx,
    output logic                busy,
    output logic                done,
    output logic                err
);

    // LOAD is the final conversion cycle: it latches the formatted line and
    // hands the first byte over, so the start bit falls on the next edge.
    // Later bytes are handed over from SEND in the last stop-bit cycle.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_CONV  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SEND  = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    move_t                      move_q, move_d;
    logic [c_row_w-1:0]         rem_q, rem_d;
    logic [3:0]                 hund_q, hund_d;
    logic [3:0]                 tens_q, tens_d;
    logic [c_line_max-1:0][7:0] line_q, line_d;
    logic [2:0]                 nbytes_q, nbytes_d;
    logic [2:0]                 idx_q, idx_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic                       w_reject;
    logic [2:0]                 w_idx_next;
    line_t                      w_line;
    logic                       w_byte_valid;
    logic [7:0]                 w_byte_data;
    logic                       w_byte_ready;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk     (clk),
        .reset   (reset),
        .i_data  (w_byte_data),
        .i_valid (w_byte_valid),
        .o_ready (w_byte_ready),
        .o_tx    (tx)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    // Request validation and line formatting from the latched move
    always_comb begin
        w_reject   = (move_q.tile == EMPTY)
                  || (move_q.col > c_col_w'(MAX_COL))
                  || (move_q.row > c_row_w'(MAX_ROW));
        w_line     = build_line(move_q.tile, move_q.col[4:0], hund_q, tens_q, rem_q[3:0]);
        w_idx_next = idx_q + 3'd1;
    end

    // Sequencer: next state, datapath updates and byte handover
    always_comb begin
        state_d      = state_q;
        move_d       = move_q;
        rem_d        = rem_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        line_d       = line_q;
        nbytes_d     = nbytes_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        w_byte_valid = 1'b0;
        w_byte_data  = 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (start_transmit) begin
                    move_d.tile = tile_e'(move_in[c_tile_msb:c_tile_lsb]);
                    move_d.col  = move_in[c_col_msb:c_col_lsb];
                    move_d.row  = move_in[c_row_msb:c_row_lsb];
                    busy_d      = 1'b1;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_reject) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = move_q.row;
                    hund_d  = 4'd0;
                    tens_d  = 4'd0;
                    // Single-digit rows need no subtraction cycles
                    state_d = (move_q.row >= c_row_w'(10)) ? ST_CONV : ST_LOAD;
                end
            end
            ST_CONV: begin
                // Hundreds are stripped first, then tens; one step per cycle
                if (rem_q >= c_row_w'(100)) begin
                    rem_d  = rem_q - c_row_w'(100);
                    hund_d = hund_q + 4'd1;
                end else begin
                    rem_d  = rem_q - c_row_w'(10);
                    tens_d = tens_q + 4'd1;
                end
                if (rem_d < c_row_w'(10)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                line_d       = w_line.bytes;
                nbytes_d     = w_line.count;
                idx_d        = 3'd0;
                w_byte_valid = 1'b1;
                w_byte_data  = w_line.bytes[0];
                state_d      = ST_SEND;
            end
            ST_SEND: begin
                // Ready here marks the last cycle of the current stop bit
                if (w_byte_ready) begin
                    if (idx_q == (nbytes_q - 3'd1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_FIN;
                    end else begin
                        idx_d        = w_idx_next;
                        w_byte_valid = 1'b1;
                        w_byte_data  = line_q[w_idx_next];
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any line in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            move_q   <= '0;
            rem_q    <= '0;
            hund_q   <= 4'd0;
            tens_q   <= 4'd0;
            line_q   <= '0;
            nbytes_q <= 3'd0;
            idx_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            move_q   <= move_d;
            rem_q    <= rem_d;
            hund_q   <= hund_d;
            tens_q   <= tens_d;
            line_q   <= line_d;
            nbytes_q <= nbytes_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trax_move_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trax_move_tx
//  Description : Self-checking bench for trax_move_tx. Expected lines come
//                from formatting the move as text; the expected line waveform
//                is derived from that text and the 8N1 framing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_trax_move_tx;

    localparam int CPB   = 8;
    localparam int TRMAX = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_transmit;
    logic [21:0] move_in;
    logic        tx;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic tx_tr   [0:TRMAX-1];
    logic busy_tr [0:TRMAX-1];
    logic done_tr [0:TRMAX-1];
    logic err_tr  [0:TRMAX-1];

    trax_move_tx #(
        .CLKS_PER_BIT (CPB),
        .MAX_COL      (26),
        .MAX_ROW      (999)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .move_in        (move_in),
        .start_transmit (start_transmit),
        .tx             (tx),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Issue one request and check the whole response cycle by cycle.
    // other_at: cycle at which a second request is pulsed (0 = none)
    // reset_at: cycle whose closing edge sees reset (0 = none)
    task automatic run_line(input logic [21:0] mv, input int other_at,
                            input logic [21:0] other_mv, input int reset_at);
        int    tile, col, row, h, t, s, n, d, limit;
        int    bad_tx, bad_busy, bad_err, done_cnt, done_at, first;
        int    off, bi, bt, got;
        bit    ok, aborted;
        byte   tc, b;
        logic  etx, ebusy, eerr;
        string line;

        tile = int'(mv[21:20]);
        col  = int'(mv[19:10]);
        row  = int'(mv[9:0]);
        ok   = (tile != 0) && (col <= 26) && (row <= 999);
        h    = row / 100;
        t    = (row % 100) / 10;
        s    = 3 + h + t;
        case (tile)
            1:       tc = 8'h2B;
            2:       tc = 8'h2F;
            default: tc = 8'h5C;
        endcase
        line  = $sformatf("%c%0d%c%c", 8'h40 + col, row, tc, 8'h0A);
        n     = line.len();
        d     = ok ? s + 10 * n * CPB : 0;
        limit = ok ? d + 3 : 8;
        if (reset_at > 0) limit = reset_at + 8;

        @(negedge clk);
        move_in        = mv;
        start_transmit = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            tx_tr[k]   = tx;
            busy_tr[k] = busy;
            done_tr[k] = done;
            err_tr[k]  = err;
            @(negedge clk);
            start_transmit = (k == other_at);
            if (k == other_at) move_in = other_mv;
            reset = (k == reset_at);
        end
        start_transmit = 1'b0;
        reset          = 1'b0;

        bad_tx = 0; bad_busy = 0; bad_err = 0;
        done_cnt = 0; done_at = 0; first = 0;
        for (int k = 1; k <= limit; k++) begin
            aborted = (reset_at > 0) && (k > reset_at);
            if (!ok) begin
                etx   = 1'b1;
                ebusy = (k == 1);
                eerr  = (k == 2);
            end else begin
                eerr  = 1'b0;
                ebusy = (k < d);
                etx   = 1'b1;
                if (k >= s && k < d) begin
                    off = k - s;
                    bi  = off / (10 * CPB);
                    bt  = (off % (10 * CPB)) / CPB;
                    b   = line[bi];
                    if (bt == 0)      etx = 1'b0;
                    else if (bt == 9) etx = 1'b1;
                    else              etx = b[bt-1];
                end
            end
            if (aborted) begin
                etx = 1'b1; ebusy = 1'b0; eerr = 1'b0;
            end
            if (tx_tr[k]   !== etx)   bad_tx++;
            if (busy_tr[k] !== ebusy) bad_busy++;
            if (err_tr[k]  !== eerr)  bad_err++;
            if (done_tr[k] === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (first == 0 && tx_tr[k] === 1'b0) first = k;
        end

        chk("tx_wave_bad_cycles", bad_tx, 0);
        chk("busy_bad_cycles", bad_busy, 0);
        chk("err_bad_cycles", bad_err, 0);
        chk("done_pulses", done_cnt, (ok && reset_at == 0) ? 1 : 0);
        if (reset_at > 0) begin
            chk("abort_tx", int'(tx_tr[reset_at+1]), 1);
            chk("abort_busy", int'(busy_tr[reset_at+1]), 0);
        end
        if (ok) begin
            chk("first_start_cycle", first, s);
            if (reset_at == 0) begin
                chk("done_cycle", done_at, d);
                // Recover bytes by mid-bit sampling from the first falling edge
                if (first > 0) begin
                    for (int i = 0; i < n; i++) begin
                        got = 0;
                        for (int j = 1; j <= 8; j++) begin
                            if (tx_tr[first + i*10*CPB + j*CPB + CPB/2] === 1'b1)
                                got = got | (1 << (j - 1));
                        end
                        chk($sformatf("byte%0d_of_%s", i, line.substr(0, n-2)), got, int'(line[i]));
                    end
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [21:0] rmv;
        reset          = 1'b1;
        start_transmit = 1'b0;
        move_in        = 22'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Plus, A1: shortest line, first start bit at cycle 3
        run_line({2'b01, 10'd1, 10'd1}, 0, 22'd0, 0);
        // Slash, column 0 row 0: "@0/" with a single zero digit
        run_line({2'b10, 10'd0, 10'd0}, 0, 22'd0, 0);
        // Bslash, Z205: internal zero kept, start bit at cycle 5
        run_line({2'b11, 10'd26, 10'd205}, 0, 22'd0, 0);
        // Worst-case conversion
        run_line({2'b01, 10'd3, 10'd999}, 0, 22'd0, 0);
        // Boundary row 100 and row 10
        run_line({2'b10, 10'd5, 10'd100}, 0, 22'd0, 0);
        run_line({2'b01, 10'd2, 10'd10}, 0, 22'd0, 0);
        // Rejections: empty tile, column 27, row 1000
        run_line({2'b00, 10'd3, 10'd3}, 0, 22'd0, 0);
        run_line({2'b01, 10'd27, 10'd5}, 0, 22'd0, 0);
        run_line({2'b10, 10'd4, 10'd1000}, 0, 22'd0, 0);
        // Second request mid-line is ignored (row 47: start bit at cycle 7)
        run_line({2'b11, 10'd12, 10'd47}, 7 + 15*CPB, {2'b01, 10'd2, 10'd3}, 0);
        // Reset during data bits of the second byte (row 38: start at cycle 6)
        run_line({2'b10, 10'd7, 10'd38}, 0, 22'd0, 6 + 14*CPB);
        // Clean line right after the abort
        run_line({2'b01, 10'd20, 10'd100}, 0, 22'd0, 0);

        // Random moves, valid and invalid
        for (int r = 0; r < 8; r++) begin
            rmv[21:20] = 2'($urandom_range(0, 3));
            rmv[19:10] = 10'($urandom_range(0, 28));
            rmv[9:0]   = 10'($urandom_range(0, 1023));
            run_line(rmv, 0, 22'd0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
